// File: rtl/bus_arbiter_pkg.sv
// Shared CPU definitions: arbiter FSM states, access mask encodings and the
// default memory read latency.
package bus_arbiter_pkg;

  localparam int unsigned MEM_LATENCY_DEFAULT = 1;

  localparam logic [2:0] RDMASK_NONE = 3'b000;
  localparam logic [2:0] RDMASK_B    = 3'b001;
  localparam logic [2:0] RDMASK_H    = 3'b010;
  localparam logic [2:0] RDMASK_W    = 3'b100;

  localparam logic [1:0] WRMASK_NONE = 2'b00;
  localparam logic [1:0] WRMASK_B    = 2'b01;
  localparam logic [1:0] WRMASK_H    = 2'b10;
  localparam logic [1:0] WRMASK_W    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Two-requester round-robin memory arbiter (CPU core and debug/DMA port).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate, latch winner's fields on a request
// ST_ACCESS | one cycle; winner's grant pulse, memory bus driven
// ST_WAIT   | MEM_LATENCY cycles; memory bus held, read data captured at end
// ST_RESP   | one cycle; owner's completion pulse, o_rdata valid
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic [2:0]  i_rd_mask0,
  input  logic [2:0]  i_rd_mask1,
  input  logic [1:0]  i_wr_mask0,
  input  logic [1:0]  i_wr_mask1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [2:0]  o_mem_rd_mask,
  output logic [1:0]  o_mem_wr_mask,
  input  logic [31:0] i_mem_rd_data
);

  arb_state_e  state, state_nxt;
  logic        last_gnt;   // also identifies the current transaction owner
  logic [3:0]  lat_cnt;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  rd_mask_q;
  logic [1:0]  wr_mask_q;
  logic        win1, take, wait_done;
  logic [2:0]  rd_sel;
  logic [1:0]  wr_sel;

  // requester 1 wins if alone, or if both ask and 0 had the last grant
  assign win1   = i_req1 & (~i_req0 | ~last_gnt);
  assign rd_sel = win1 ? i_rd_mask1 : i_rd_mask0;
  assign wr_sel = win1 ? i_wr_mask1 : i_wr_mask0;

  assign o_mem_addr    = addr_q;
  assign o_mem_wr_data = wdata_q;

  // state register, reset aborts any transaction immediately
  always_ff @(posedge sys_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_nxt     = state;
    take          = 1'b0;
    wait_done     = 1'b0;
    o_gnt0        = 1'b0;
    o_gnt1        = 1'b0;
    o_rvalid0     = 1'b0;
    o_rvalid1     = 1'b0;
    o_mem_rd_mask = RDMASK_NONE;
    o_mem_wr_mask = WRMASK_NONE;
    case (state)
      ST_IDLE: begin
        if (i_req0 | i_req1) begin
          take      = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_gnt0        = ~last_gnt;
        o_gnt1        = last_gnt;
        o_mem_rd_mask = rd_mask_q;
        o_mem_wr_mask = wr_mask_q;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        o_mem_rd_mask = rd_mask_q;
        o_mem_wr_mask = wr_mask_q;
        if (lat_cnt == 4'd1) begin
          wait_done = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        o_rvalid0 = ~last_gnt;
        o_rvalid1 = last_gnt;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // latched request, grant pointer, latency down-counter and read data
  always_ff @(posedge sys_clk or posedge i_reset) begin
    if (i_reset) begin
      last_gnt  <= 1'b1;
      lat_cnt   <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_mask_q <= RDMASK_NONE;
      wr_mask_q <= WRMASK_NONE;
      o_rdata   <= '0;
    end else begin
      if (take) begin
        last_gnt  <= win1;
        addr_q    <= win1 ? i_addr1 : i_addr0;
        wdata_q   <= win1 ? i_wdata1 : i_wdata0;
        wr_mask_q <= wr_sel;
        // a write wins over a simultaneous read
        rd_mask_q <= (wr_sel != WRMASK_NONE) ? RDMASK_NONE : rd_sel;
        lat_cnt   <= 4'(MEM_LATENCY);
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (wait_done)
        o_rdata <= (rd_mask_q != RDMASK_NONE) ? i_mem_rd_data : '0;
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, default 1, memory read-data delay in cycles after the ACCESS cycle; legal range 1..15.
REQ-002 sys_clk  in  1  system clock (gated core clock); all state updates on its rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-high.
REQ-004 i_req0, i_req1  in  1 each  access request; requester 0 is the CPU core, requester 1 is the debug/DMA port.
REQ-005 i_addr0, i_addr1  in  32 each  byte address.
REQ-006 i_wdata0, i_wdata1  in  32 each  write data.
REQ-007 i_rd_mask0, i_rd_mask1  in  3 each  read mask; 0 means no read.
REQ-008 i_wr_mask0, i_wr_mask1  in  2 each  write mask; 0 means no write.
REQ-009 o_gnt0, o_gnt1  out  1 each  grant pulse.
REQ-010 o_rvalid0, o_rvalid1  out  1 each  completion pulse, for both reads and writes.
REQ-011 o_rdata  out  32  read data, shared by both requesters; qualified by o_rvalidN.
REQ-012 o_mem_addr, o_mem_wr_data  out  32 each  memory address and write data.
REQ-013 o_mem_rd_mask  out  3; o_mem_wr_mask  out  2  memory access masks.
REQ-014 i_mem_rd_data  in  32  memory read data.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACCESS, WAIT and RESP.
REQ-016 In IDLE with any i_reqN high, the block SHALL latch the winner's addr, wdata and masks and enter ACCESS; with no request it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin; with both requests high, the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins the first contest.
REQ-018 A lone request SHALL win regardless of the pointer; the pointer SHALL update only on a grant.
REQ-019 o_gntN SHALL be high for exactly the one ACCESS cycle of the winner's transaction.
REQ-020 Requesters SHALL hold their request and its fields stable until they see o_gntN; a request still high in IDLE after a grant is a new request.
REQ-021 From the start of ACCESS through the end of WAIT, o_mem_addr, o_mem_wr_data and the masks SHALL be driven from the latched values and held stable.
REQ-022 In IDLE and RESP both memory masks SHALL be 0, and o_mem_addr SHALL hold its last value.
REQ-023 If both latched masks are nonzero, the write SHALL take precedence: o_mem_rd_mask is forced to 0 and o_rdata is 0.
REQ-024 WAIT SHALL last exactly MEM_LATENCY cycles, counted by a 4-bit down-counter loaded on entry to ACCESS.
REQ-025 On leaving WAIT, a read SHALL capture i_mem_rd_data into o_rdata; for a write or no-op, o_rdata SHALL be loaded with 0.
REQ-026 RESP SHALL last one cycle; during it the transaction owner's o_rvalidN SHALL be high; the next state is IDLE.
REQ-027 o_rdata SHALL hold its value until the next RESP.
REQ-028 Latency: a request sampled at edge E SHALL give o_gnt during cycle E+1 and o_rvalid during cycle E+2+MEM_LATENCY; back-to-back transactions are 3+MEM_LATENCY cycles apart.
REQ-029 A request with both masks 0 SHALL be granted and completed as a no-op.
REQ-030 Requests arriving outside IDLE SHALL be ignored until IDLE, with no loss of a held request.

Reset
REQ-031 i_reset SHALL force IDLE immediately, abort any transaction with no o_rvalid, and zero the pointer-independent outputs: o_gnt*, o_rvalid*, o_rdata, o_mem_addr, o_mem_wr_data and both masks.
REQ-032 i_reset SHALL set the last-grant pointer to 1 and the latency counter to 0.

Structure
REQ-033 The shared CPU package SHALL hold the state enum, the RDMASK_* and WRMASK_* constants, and the MEM_LATENCY default.
REQ-034 The block SHALL be a single module with no sub-module; the arbiter, counter and FSM are inline.

Verification
REQ-035 Single read, MEM_LATENCY=1: req0 with addr 0x100, rd_mask RDMASK_W, memory returning 0xDEADBEEF -> gnt0 at E+1, rvalid0 at E+3, o_rdata=0xDEADBEEF.
REQ-036 Simultaneous req0 and req1 held continuously -> grants alternate 0,1,0,1 with a spacing of 4 cycles each.
REQ-037 Write from req1: addr 0x20, data 0x12345678, wr_mask 2 -> memory sees wr_mask=2 during ACCESS and WAIT, rd_mask=0, then rvalid1 with o_rdata=0.
REQ-038 MEM_LATENCY=3 read -> memory address stable for 4 cycles, rvalid0 at E+5.
REQ-039 i_reset asserted during WAIT -> all outputs 0 within the same cycle, no rvalid, and the next contest is won by requester 0.
REQ-040 Both masks nonzero (rd 4, wr 1) -> o_mem_rd_mask=0, o_mem_wr_mask=1, o_rdata=0 at rvalid.
